// File: rtl/sw_diag_score_pipe.sv
// Smith-Waterman diagonal score pipeline.
// Two stages: (1) pick the match/mismatch/gap delta and register it with the
// diagonal value, (2) add, clamp to [0, 2^SCORE_W-1] and present under
// valid/ready. A running maximum and its beat index are kept on the output
// side so the host can locate the best alignment cell.
module sw_diag_score_pipe #(
    parameter int SCORE_W  = 8,
    parameter int CHAR_W   = 2,
    parameter int MATCH    = 2,
    parameter int MISMATCH = 1,
    parameter int GAP      = 2,
    parameter int IDX_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SCORE_W-1:0] diag,
    input  logic [CHAR_W-1:0]  q_char,
    input  logic [CHAR_W-1:0]  s_char,
    input  logic               gap,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] sum,
    output logic               is_match,
    output logic               sat_hi,
    output logic               sat_lo,
    output logic [SCORE_W-1:0] max_score,
    output logic [IDX_W-1:0]   max_idx
);

    // Two guard bits: one for the sign, one for overflow past all-ones.
    localparam int DW = SCORE_W + 2;

    localparam logic signed [DW-1:0] D_MATCH = DW'(MATCH);
    localparam logic signed [DW-1:0] D_MISM  = -(DW'(MISMATCH));
    localparam logic signed [DW-1:0] D_GAP   = -(DW'(GAP));

    // Stage-1 payload.
    typedef struct packed {
        logic signed [DW-1:0]  delta;
        logic [SCORE_W-1:0]    diag;
        logic                  is_match;
    } s1_t;

    // vld_pipe[1] = stage-1 holds a beat, vld_pipe[2] = output holds a beat.
    logic [2:1] vld_pipe;
    s1_t        s1_d, s1_q;

    logic s1_adv, s2_adv, out_hs;

    logic signed [DW-1:0] t;
    logic [SCORE_W-1:0]   sum_d;
    logic                 sat_hi_d, sat_lo_d;

    logic [IDX_W-1:0] cnt;
    logic             first;

    // Each stage may load when it is empty or its content moves on this cycle.
    assign s2_adv   = !vld_pipe[2] || out_ready;
    assign s1_adv   = !vld_pipe[1] || s2_adv;
    assign in_ready = s1_adv;
    assign out_valid = vld_pipe[2];
    assign out_hs   = vld_pipe[2] && out_ready;

    // Score selection: gap wins over the letter comparison.
    always_comb begin
        s1_d          = '0;
        s1_d.diag     = diag;
        if (gap) begin
            s1_d.delta = D_GAP;
        end else if (q_char == s_char) begin
            s1_d.delta    = D_MATCH;
            s1_d.is_match = 1'b1;
        end else begin
            s1_d.delta = D_MISM;
        end
    end

    // Stage-1 register: captures the beat on the input handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            s1_q        <= '0;
        end else if (s1_adv) begin
            vld_pipe[1] <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    // Add and clamp. Zero-extended diag plus signed delta never wraps in DW bits.
    always_comb begin
        t        = $signed({2'b00, s1_q.diag}) + s1_q.delta;
        sum_d    = t[SCORE_W-1:0];
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b0;
        if (t[DW-1]) begin
            sum_d    = '0;
            sat_lo_d = 1'b1;
        end else if (t[DW-2]) begin
            sum_d    = '1;
            sat_hi_d = 1'b1;
        end
    end

    // Output register: loads only when free or being drained, so it holds under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[2] <= 1'b0;
            sum         <= '0;
            is_match    <= 1'b0;
            sat_hi      <= 1'b0;
            sat_lo      <= 1'b0;
        end else if (s2_adv) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                sum      <= sum_d;
                is_match <= s1_q.is_match;
                sat_hi   <= sat_hi_d;
                sat_lo   <= sat_lo_d;
            end
        end
    end

    // Beat counter and running maximum; clear starts a new run at this beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            max_score <= '0;
            max_idx   <= '0;
            first     <= 1'b1;
        end else if (clear) begin
            if (out_hs) begin
                cnt       <= IDX_W'(1);
                max_score <= sum;
                max_idx   <= '0;
                first     <= 1'b0;
            end else begin
                cnt       <= '0;
                max_score <= '0;
                max_idx   <= '0;
                first     <= 1'b1;
            end
        end else if (out_hs) begin
            cnt <= cnt + 1'b1;
            if (first || (sum > max_score)) begin
                max_score <= sum;
                max_idx   <= cnt;
                first     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sw_diag_score_pipe.sv
// Directed bench for sw_diag_score_pipe with default parameters.
module tb_sw_diag_score_pipe;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, gap, clear, out_valid, out_ready;
    logic [7:0] diag, sum, max_score;
    logic [1:0] q_char, s_char;
    logic       is_match, sat_hi, sat_lo;
    logic [9:0] max_idx;

    int n_chk  = 0;
    int n_fail = 0;

    sw_diag_score_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .diag(diag), .q_char(q_char), .s_char(s_char), .gap(gap),
        .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .is_match(is_match), .sat_hi(sat_hi), .sat_lo(sat_lo),
        .max_score(max_score), .max_idx(max_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat with out_ready high; checks the 2-cycle latency and result.
    task automatic beat(input logic [7:0] d, input logic [1:0] q, input logic [1:0] s,
                        input logic g, input logic [7:0] es, input logic em,
                        input logic eh, input logic el);
        diag = d; q_char = q; s_char = s; gap = g; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_ov0", 32'(out_valid), 0);
        step();
        chk("ov", 32'(out_valid), 1);
        chk("sum", 32'(sum), 32'(es));
        chk("is_match", 32'(is_match), 32'(em));
        chk("sat_hi", 32'(sat_hi), 32'(eh));
        chk("sat_lo", 32'(sat_lo), 32'(el));
    endtask

    initial begin
        int  i, j;
        logic held, saw_stall, in_hs;
        logic [7:0] held_val;

        rst = 1'b1; in_valid = 1'b0; gap = 1'b0; clear = 1'b0; out_ready = 1'b1;
        diag = '0; q_char = '0; s_char = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_ir", 32'(in_ready), 1);
        chk("rst_max", 32'(max_score), 0);
        chk("rst_idx", 32'(max_idx), 0);
        chk("rst_sum", 32'(sum), 0);

        // Basic match, floor, gap, exact zero, ceiling and exact all-ones.
        beat(8'd5,   2'b01, 2'b01, 1'b0, 8'd7,   1'b1, 1'b0, 1'b0); // idx0
        beat(8'd0,   2'b00, 2'b11, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1); // idx1
        beat(8'd1,   2'b00, 2'b00, 1'b1, 8'd0,   1'b0, 1'b0, 1'b1); // idx2
        beat(8'd2,   2'b00, 2'b00, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0); // idx3
        beat(8'd254, 2'b10, 2'b10, 1'b0, 8'd255, 1'b1, 1'b1, 1'b0); // idx4
        beat(8'd253, 2'b10, 2'b10, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0); // idx5 tie
        step();
        chk("max_sat", 32'(max_score), 255);
        chk("idx_tie", 32'(max_idx), 4);
        chk("ov_drained", 32'(out_valid), 0);

        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_max", 32'(max_score), 0);
        chk("clr_idx", 32'(max_idx), 0);

        // Back-to-back beats with a three-cycle downstream stall.
        i = 0; j = 0; held = 1'b0; saw_stall = 1'b0; held_val = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (i < 6) begin
                in_valid = 1'b1; diag = 8'(i + 1); q_char = 2'b10; s_char = 2'b10; gap = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) chk("bp_hold", 32'(sum), 32'(held_val));
            if (!in_ready) saw_stall = 1'b1;
            in_hs = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("bp_sum", 32'(sum), 32'(j + 3));
                j++;
            end
            held = out_valid && !out_ready;
            held_val = sum;
            if (in_hs) i++;
            if (j == 6) break;
        end
        chk("bp_all", 32'(j), 6);
        chk("bp_stall", 32'(saw_stall), 1);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_max", 32'(max_score), 8);
        chk("bp_idx", 32'(max_idx), 5);

        clear = 1'b1; step(); clear = 1'b0;

        // Sums 4,9,9,3 then clear on the handshake of a beat with sum 2.
        beat(8'd2, 2'b01, 2'b01, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
        beat(8'd7, 2'b01, 2'b01, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0);
        beat(8'd7, 2'b01, 2'b01, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0);
        beat(8'd1, 2'b01, 2'b01, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
        beat(8'd0, 2'b01, 2'b01, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        chk("run_max", 32'(max_score), 9);
        chk("run_idx", 32'(max_idx), 1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clrhs_max", 32'(max_score), 2);
        chk("clrhs_idx", 32'(max_idx), 0);
        // Counter must now be 1: the next larger sum lands at index 1.
        beat(8'd3, 2'b01, 2'b01, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0);
        step();
        chk("cnt1_max", 32'(max_score), 5);
        chk("cnt1_idx", 32'(max_idx), 1);

        // Reset with a beat in flight discards it.
        diag = 8'd9; q_char = 2'b00; s_char = 2'b00; gap = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("mid_rst_ov", 32'(out_valid), 0);
        chk("mid_rst_max", 32'(max_score), 0);
        chk("mid_rst_ir", 32'(in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_diag_score_pipe.md
Name: sw_diag_score_pipe

Overview:
Parametrised, pipelined successor to the 2-bit diagonal score adder in the Smith-Waterman array. Per accepted beat it:
- selects a match, mismatch or gap score from the query/subject letters;
- adds the score to the up-left diagonal value with floor-at-zero and ceiling saturation;
- streams the result out under valid/ready;
- tracks the running maximum and its beat index for alignment reporting.

Parameters:
SCORE_W, 8, width of the diag and sum values (unsigned, 2..16)
CHAR_W, 2, letter width (2 = nucleotide code)
MATCH, 2, added on match (unsigned, < 2^SCORE_W)
MISMATCH, 1, subtracted on mismatch (unsigned)
GAP, 2, subtracted on gap (unsigned)
IDX_W, 10, width of the beat counter and max_idx

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
diag  in  SCORE_W  up-left diagonal score
q_char  in  CHAR_W  query letter
s_char  in  CHAR_W  subject letter
gap  in  1  1 = gap move (letters ignored)
clear  in  1  restart max tracker and beat counter
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  SCORE_W  saturated diagonal score
is_match  out  1  beat was a non-gap match
sat_hi  out  1  result clamped to 2^SCORE_W-1
sat_lo  out  1  result floored to 0
max_score  out  SCORE_W  largest sum transferred since reset/clear
max_idx  out  IDX_W  beat index of max_score

Behaviour:
- Reset (rst=1 at clk edge):
  - all pipeline valids, out_valid, sum, is_match, sat_hi, sat_lo, max_score, max_idx and the beat counter go to 0;
  - in_ready reads 1 on the first cycle after reset;
  - reset mid-stream discards all in-flight beats.
- Stage 1 (select), registered on input handshake:
  - gap=1: delta = -GAP;
  - else q_char==s_char: delta = +MATCH, is_match=1;
  - else: delta = -MISMATCH.
  - delta is held signed, SCORE_W+2 bits; diag is registered alongside.
- Stage 2 (add/clamp), registered:
  - t = diag + delta, computed in SCORE_W+2 signed bits.
  - t<0: sum=0, sat_lo=1.
  - t>2^SCORE_W-1: sum=all ones, sat_hi=1.
  - else: sum=t, both flags 0.
  - Exactly zero is not sat_lo.
- Latency: 2 cycles from input handshake to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Handshake:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. in_ready is combinational from out_ready; no other combinational paths.
  - Outputs hold stable while out_valid && !out_ready.
  - No beat is dropped or duplicated under any valid/ready pattern.
- Beat counter: increments by 1 on each output handshake (out_valid && out_ready) and wraps modulo 2^IDX_W.
- Max tracker, updated on each output handshake with the pre-increment counter value as index:
  - if sum > max_score, max_score<=sum and max_idx<=index;
  - ties keep the earlier index;
  - the first transfer after reset/clear always loads, even when sum=0.
- clear (synchronous, one cycle):
  - counter, max_score and max_idx go to 0 and the first-transfer flag is re-armed;
  - the pipeline is not flushed.
  - clear coincident with an output handshake: that beat is index 0 of the new run, so max_score=sum, max_idx=0, counter=1.
- rst has priority over clear.

Test Plan:
- Reset, then no stimulus: out_valid=0, in_ready=1, max_score=0, max_idx=0.
- diag=5, q=s=2'b01, gap=0, out_ready=1 -> 2 cycles later sum=7, is_match=1, sat flags 0.
- diag=0, q=0, s=3, gap=0 -> sum=0, sat_lo=1. Then diag=1, gap=1 -> sum=0, sat_lo=1. Then diag=2, gap=1 -> sum=0, sat_lo=0.
- diag=254, match -> sum=255, sat_hi=1. Then diag=253, match -> sum=255, sat_hi=0.
- Back-to-back beats diag=1..6 (all match), out_ready low for cycles 3-5 -> in_ready drops, sum held stable, outputs 3,4,5,6,7,8 in order, none lost.
- Sums 4,9,9,3 -> max_score=9, max_idx=1. Then clear asserted on the handshake of the next beat (sum 2) -> max_score=2, max_idx=0, counter=1.
